// File: rtl/line_rasterizer.sv
// Bresenham line engine driving the frame buffer write port, one pixel per HOLD_CYCLES.
// Optional LINE_RASTERIZER_CLIP_EN suppresses brush for pixels beyond COORD_MAX.
module line_rasterizer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned COORD_MAX   = 127
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic [2:0] color,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic       brush,
  output logic [2:0] newColor,
  output logic       busy,
  output logic       done
);

`ifdef LINE_RASTERIZER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  localparam logic [7:0] CMAX = 8'(COORD_MAX);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PLOT} state_t;

  state_t            state_q;
  logic [7:0]        x0_q, y0_q, x1_q, y1_q;
  logic [2:0]        color_q;
  logic signed [10:0] dx_q, dy_q, err_q;
  logic              sx_neg_q, sy_neg_q;
  logic [HW-1:0]     hold_q;
  logic [7:0]        wx_q, wy_q;
  logic [2:0]        newColor_q;
  logic              brush_q, busy_q, done_q;

  logic signed [10:0] dx_s, dy_s, e2, err_d;
  logic              step_x, step_y, at_end, last_hold;
  logic [7:0]        wx_d, wy_d;

  function automatic logic pix_ok(input logic [7:0] x, input logic [7:0] y);
    return !CLIP || ((x <= CMAX) && (y <= CMAX));
  endfunction

  always_comb begin
    dx_s = (x1_q >= x0_q) ? $signed({3'b000, x1_q - x0_q})
                          : $signed({3'b000, x0_q - x1_q});
    dy_s = (y1_q >= y0_q) ? -$signed({3'b000, y1_q - y0_q})
                          : -$signed({3'b000, y0_q - y1_q});
    e2     = err_q <<< 1;
    step_x = (e2 >= dy_q);
    step_y = (e2 <= dx_q);
    err_d  = err_q + (step_x ? dy_q : 11'sd0) + (step_y ? dx_q : 11'sd0);
    wx_d   = wx_q;
    wy_d   = wy_q;
    if (step_x) wx_d = sx_neg_q ? wx_q - 8'd1 : wx_q + 8'd1;
    if (step_y) wy_d = sy_neg_q ? wy_q - 8'd1 : wy_q + 8'd1;
    at_end    = (wx_q == x1_q) && (wy_q == y1_q);
    last_hold = (hold_q == HW'(HOLD_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      hold_q     <= '0;
      wx_q       <= '0;
      wy_q       <= '0;
      newColor_q <= '0;
      brush_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            color_q <= color;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          dx_q       <= dx_s;
          dy_q       <= dy_s;
          err_q      <= dx_s + dy_s;
          sx_neg_q   <= (x1_q < x0_q);
          sy_neg_q   <= (y1_q < y0_q);
          wx_q       <= x0_q;
          wy_q       <= y0_q;
          newColor_q <= color_q;
          brush_q    <= pix_ok(x0_q, y0_q);
          hold_q     <= '0;
          state_q    <= PLOT;
        end
        PLOT: begin
          if (!last_hold) begin
            hold_q <= hold_q + 1'b1;
          end else if (at_end) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            brush_q <= 1'b0;
          end else begin
            // wx/wy double as the Bresenham cursor, so the step lands directly on the outputs
            err_q   <= err_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            brush_q <= pix_ok(wx_d, wy_d);
            hold_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wx       = wx_q;
  assign wy       = wy_q;
  assign brush    = brush_q;
  assign newColor = newColor_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer with HOLD_CYCLES=2; outputs sampled on the falling edge.
module tb_line_rasterizer;

`ifdef LINE_RASTERIZER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] x0, y0, x1, y1;
  logic [2:0] color;
  logic [7:0] wx, wy;
  logic       brush, busy, done;
  logic [2:0] newColor;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [7:0] exp_x [16];
  logic [7:0] exp_y [16];

  line_rasterizer #(.HOLD_CYCLES(2), .COORD_MAX(127)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
    .wx(wx), .wy(wy), .brush(brush), .newColor(newColor),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_px(input int i, input logic [7:0] x, input logic [7:0] y);
    exp_x[i] = x;
    exp_y[i] = y;
  endtask

  // Issues a one-cycle start and checks setup, every held pixel and the done pulse.
  task automatic run_line(input string nm, input logic [7:0] ax0, input logic [7:0] ay0,
                          input logic [7:0] ax1, input logic [7:0] ay1,
                          input logic [2:0] c, input int n, input bit inject);
    logic eb;
    @(negedge clk);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_setup_busy"}, 32'(busy), 32'd1);
    check({nm, "_setup_brush"}, 32'(brush), 32'd0);
    for (int i = 0; i < n; i++) begin
      eb = !CLIP || ((exp_x[i] <= 8'd127) && (exp_y[i] <= 8'd127));
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        check($sformatf("%s_p%0d_h%0d_wx", nm, i, h), 32'(wx), 32'(exp_x[i]));
        check($sformatf("%s_p%0d_h%0d_wy", nm, i, h), 32'(wy), 32'(exp_y[i]));
        check($sformatf("%s_p%0d_h%0d_brush", nm, i, h), 32'(brush), 32'(eb));
        check($sformatf("%s_p%0d_h%0d_color", nm, i, h), 32'(newColor), 32'(c));
        check($sformatf("%s_p%0d_h%0d_busy", nm, i, h), 32'(busy), 32'd1);
        check($sformatf("%s_p%0d_h%0d_done", nm, i, h), 32'(done), 32'd0);
        if (inject && i == 1) begin
          start = (h == 0);
          x0 = 8'd50; y0 = 8'd60; x1 = 8'd70; y1 = 8'd20; color = 3'd1;
        end
      end
    end
    @(negedge clk);
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_done_busy"}, 32'(busy), 32'd0);
    check({nm, "_done_brush"}, 32'(brush), 32'd0);
    @(negedge clk);
    check({nm, "_done_clear"}, 32'(done), 32'd0);
    check({nm, "_idle_wx"}, 32'(wx), 32'(exp_x[n-1]));
    check({nm, "_idle_color"}, 32'(newColor), 32'(c));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_brush", 32'(brush), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wx", 32'(wx), 32'd0);
    check("rst_wy", 32'(wy), 32'd0);
    check("rst_color", 32'(newColor), 32'd0);

    // horizontal line
    for (int i = 0; i < 4; i++) set_px(i, 8'(i), 8'd0);
    run_line("hline", 8'd0, 8'd0, 8'd3, 8'd0, 3'd5, 4, 1'b0);

    // shallow positive slope
    set_px(0, 8'd0, 8'd0); set_px(1, 8'd1, 8'd1); set_px(2, 8'd2, 8'd1);
    set_px(3, 8'd3, 8'd2); set_px(4, 8'd4, 8'd2);
    run_line("slope", 8'd0, 8'd0, 8'd4, 8'd2, 3'd3, 5, 1'b0);

    // negative-x diagonal with a start pulse while busy
    set_px(0, 8'd5, 8'd5); set_px(1, 8'd4, 8'd6); set_px(2, 8'd3, 8'd7); set_px(3, 8'd2, 8'd8);
    run_line("diag", 8'd5, 8'd5, 8'd2, 8'd8, 3'd6, 4, 1'b1);

    // single pixel
    set_px(0, 8'd9, 8'd9);
    run_line("point", 8'd9, 8'd9, 8'd9, 8'd9, 3'd7, 1, 1'b0);

    // crosses the canvas edge; brush depends on clipping build
    for (int i = 0; i < 5; i++) set_px(i, 8'(126 + i), 8'd0);
    run_line("edge", 8'd126, 8'd0, 8'd130, 8'd0, 3'd2, 5, 1'b0);

    // start held high: second line accepted in the done cycle
    @(negedge clk);
    x0 = 8'd9; y0 = 8'd9; x1 = 8'd9; y1 = 8'd9; color = 3'd4; start = 1'b1;
    repeat (3) @(negedge clk);
    check("held_px_wx", 32'(wx), 32'd9);
    check("held_px_brush", 32'(brush), 32'd1);
    @(negedge clk);
    check("held_done", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("held_resetup_busy", 32'(busy), 32'd1);
    check("held_resetup_brush", 32'(brush), 32'd0);
    @(negedge clk);
    check("held_px2_brush", 32'(brush), 32'd1);
    check("held_px2_wy", 32'(wy), 32'd9);
    repeat (2) @(negedge clk);
    check("held_done2", 32'(done), 32'd1);

    // reset during the third pixel of a long line
    @(negedge clk);
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd10; y1 = 8'd0; color = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rmid_px2_wx", 32'(wx), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rmid_brush", 32'(brush), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_wx", 32'(wx), 32'd0);
    check("rmid_color", 32'(newColor), 32'd0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check($sformatf("rmid_quiet%0d_done", k), 32'(done), 32'd0);
      check($sformatf("rmid_quiet%0d_brush", k), 32'(brush), 32'd0);
    end
    for (int i = 0; i < 4; i++) set_px(i, 8'(i), 8'd0);
    run_line("after_rst", 8'd0, 8'd0, 8'd3, 8'd0, 3'd5, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
